cnn_mem_reader: RTL and testbench

Read-side initiator for the 8-bit CNN weight/activation memory (chipselect/read/address/readdata slave with registered 1-cycle read data).
Accepts a descriptor (start address, byte count) and issues one read per cycle to the memory.
Buffers returned bytes in a small prefetch FIFO and streams them to the CNN datapath over a valid/ready byte stream with a last flag.
Sits between the layer sequencer (descriptor source) and the convolution/FC compute units.

---
 rtl/cnn_mem_pkg.sv | 11 +
 rtl/cnn_mem_reader_if.sv | 21 ++
 rtl/cnn_mem_rd_fifo.sv | 46 ++++
 rtl/cnn_mem_reader.sv | 139 +++++++++++++
 tb/tb_cnn_mem_reader.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_mem_pkg.sv
// Shared constants and types for the CNN memory read path.
package cnn_mem_pkg;
    localparam int CNN_MEM_ADDR_W = 19;
    localparam int CNN_MEM_DATA_W = 8;
    localparam int CNN_MEM_SIZE   = 375000;

    typedef logic [18:0] cnn_addr_t;
    typedef logic [7:0]  cnn_byte_t;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} rd_state_e;
endpackage

// File: rtl/cnn_mem_reader_if.sv
// Read/write bus of the CNN weight/activation memory; master is the initiator.
interface cnn_mem_reader_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
);
    logic              mem_chipselect;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_readdata;

    modport master (
        output mem_chipselect, mem_read, mem_write, mem_writedata, mem_address,
        input  mem_readdata
    );
    modport slave (
        input  mem_chipselect, mem_read, mem_write, mem_writedata, mem_address,
        output mem_readdata
    );
endinterface

// File: rtl/cnn_mem_rd_fifo.sv
// Prefetch FIFO holding {last, data}; head reads as zero while empty.
module cnn_mem_rd_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     push_last,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head_data,
    output logic                     head_last,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W:0] store [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // a push into a full FIFO is fine when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);
    assign {head_last, head_data} = empty ? '0 : store[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= {push_last, push_data};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/cnn_mem_reader.sv
// Descriptor-driven byte reader from the CNN memory into a valid/ready stream.
// Optional CNN_MEM_RD_BOUNDS_CHECK_EN adds an err port and rejects out-of-range descriptors.
module cnn_mem_reader
    import cnn_mem_pkg::*;
#(
    parameter int ADDR_W     = CNN_MEM_ADDR_W,
    parameter int DATA_W     = CNN_MEM_DATA_W,
    parameter int MEM_SIZE   = CNN_MEM_SIZE,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [ADDR_W-1:0]  cmd_addr,
    input  logic [ADDR_W-1:0]  cmd_len,
    cnn_mem_reader_if.master   mem,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_last,
    output logic               busy,
    output logic               done
`ifdef CNN_MEM_RD_BOUNDS_CHECK_EN
   ,output logic               err
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || DATA_W % 8 != 0 ||
        RD_LATENCY < 1 || longint'(MEM_SIZE) > (longint'(1) << ADDR_W)) begin : g_bad_cfg
        $error("cnn_mem_reader: unsupported parameter set");
    end

    rd_state_e             state;
    logic [ADDR_W-1:0]     remaining;
    logic [CW-1:0]         inflight, fifo_count;
    logic [RD_LATENCY-1:0] vld_pipe, last_pipe;
    logic                  issue, ret, ret_last, pop, oob;
    logic                  fifo_full, fifo_empty;

`ifdef CNN_MEM_RD_BOUNDS_CHECK_EN
    assign oob = ({1'b0, cmd_addr} + {1'b0, cmd_len}) > (ADDR_W+1)'(MEM_SIZE);
`else
    assign oob = 1'b0;
`endif

    // credit: every outstanding read already owns a FIFO slot, so returns never overflow
    assign issue = (state == ISSUE) &&
                   (({1'b0, fifo_count} + {1'b0, inflight}) < (CW+1)'(FIFO_DEPTH));
    assign ret      = vld_pipe[RD_LATENCY-1];
    assign ret_last = last_pipe[RD_LATENCY-1];

    assign mem.mem_read       = issue;
    assign mem.mem_chipselect = issue;
    assign mem.mem_write      = 1'b0;
    assign mem.mem_writedata  = '0;

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;

    cnn_mem_rd_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(DATA_W)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (ret),
        .push_data (mem.mem_readdata),
        .push_last (ret_last),
        .pop       (pop),
        .head_data (out_data),
        .head_last (out_last),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // clearing the pipe on reset drops any read data still on its way back
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
            inflight  <= '0;
        end else begin
            vld_pipe  <= RD_LATENCY'({vld_pipe, issue});
            last_pipe <= RD_LATENCY'({last_pipe, remaining == ADDR_W'(1)});
            inflight  <= inflight + CW'(issue) - CW'(ret);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            cmd_ready       <= 1'b1;
            busy            <= 1'b0;
            done            <= 1'b0;
            remaining       <= '0;
            mem.mem_address <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (cmd_valid) begin
                    cmd_ready <= 1'b0;
                    busy      <= 1'b1;
                    if (oob || cmd_len == '0) begin
                        done  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        mem.mem_address <= cmd_addr;
                        remaining       <= cmd_len;
                        state           <= ISSUE;
                    end
                end
                ISSUE: if (issue) begin
                    mem.mem_address <= mem.mem_address + ADDR_W'(1);
                    remaining       <= remaining - ADDR_W'(1);
                    if (remaining == ADDR_W'(1)) state <= DRAIN;
                end
                DRAIN: if (pop && out_last) begin
                    done  <= 1'b1;
                    state <= FINISH;
                end
                FINISH: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef CNN_MEM_RD_BOUNDS_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) err <= 1'b0;
        else       err <= (state == IDLE) && cmd_valid && oob;
    end
`endif

    a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(ret && fifo_full && !pop));
endmodule

// File: tb/tb_cnn_mem_reader.sv
// Randomized bench for cnn_mem_reader with a queue-based model of the expected byte stream.
module tb_cnn_mem_reader;
    import cnn_mem_pkg::*;

    localparam int AW    = CNN_MEM_ADDR_W;
    localparam int DW    = CNN_MEM_DATA_W;
    localparam int DEPTH = 4;
    localparam int MSIZE = CNN_MEM_SIZE;

    typedef struct packed { logic l; cnn_byte_t d; } beat_t;

    logic      clk = 1'b0;
    logic      reset = 1'b1;
    logic      cmd_valid = 1'b0;
    logic      cmd_ready;
    cnn_addr_t cmd_addr = '0;
    cnn_addr_t cmd_len = '0;
    logic      out_valid, out_last, busy, done;
    logic      out_ready = 1'b0;
    cnn_byte_t out_data;
`ifdef CNN_MEM_RD_BOUNDS_CHECK_EN
    logic      err;
`endif

    always #5 clk = ~clk;

    cnn_mem_reader_if #(.ADDR_W(AW), .DATA_W(DW)) mem_bus ();

    cnn_mem_reader #(.ADDR_W(AW), .DATA_W(DW), .MEM_SIZE(MSIZE), .FIFO_DEPTH(DEPTH), .RD_LATENCY(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .mem       (mem_bus),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
`ifdef CNN_MEM_RD_BOUNDS_CHECK_EN
       ,.err       (err)
`endif
    );

    // memory with registered one-cycle read data; garbage when not read
    cnn_byte_t mem_arr [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_bus.mem_chipselect && mem_bus.mem_read) mem_bus.mem_readdata <= mem_arr[mem_bus.mem_address];
        else                                            mem_bus.mem_readdata <= 8'hEE;
    end

    int total = 0, bad = 0;
    task automatic chk(input string name, input longint act, input longint expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // model state
    beat_t     exp_q[$];
    beat_t     got_q[$];
    int        rd_cycles[$];
    int        cyc = 0, done_due = -1, err_due = -1;
    bit        idle = 1'b1, prev_stall = 1'b0;
    beat_t     prev_beat;
    int        issued = 0, popped = 0, reads_left = 0;
    cnn_addr_t exp_addr = '0;
    int        desc_reads = 0, desc_pops = 0, reads_at_pop1 = -1;
    int        acc_cyc = 0, first_vld = -1, last_hs_cyc = -1, done_cyc = -1, err_cyc = -1;
    int        rmode = 0, hold_until = 0;

    always @(negedge clk) begin
        beat_t b;
        bit    oob;
        if (reset) begin
            exp_q.delete();
            idle = 1'b1; done_due = -1; err_due = -1;
            issued = 0; popped = 0; reads_left = 0; prev_stall = 1'b0;
        end else begin
            chk("cmd_ready", cmd_ready, idle);
            chk("busy", busy, !idle);
            chk("done", done, cyc == done_due);
`ifdef CNN_MEM_RD_BOUNDS_CHECK_EN
            chk("err", err, cyc == err_due);
            if (err) err_cyc = cyc;
`endif
            if (done) done_cyc = cyc;
            chk("cs_with_read", mem_bus.mem_chipselect, mem_bus.mem_read);
            chk("mem_write", mem_bus.mem_write, 0);
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_beat", {out_last, out_data}, prev_beat);
            end
            if (out_valid) begin
                chk("valid_expected", exp_q.size() > 0, 1);
                if (first_vld < 0) first_vld = cyc;
            end
            if (mem_bus.mem_read) begin
                chk("rd_credit", (issued - popped) < DEPTH, 1);
                chk("rd_expected", reads_left > 0, 1);
                chk("rd_addr", mem_bus.mem_address, exp_addr);
                exp_addr++; reads_left--; issued++; desc_reads++;
                rd_cycles.push_back(cyc);
            end
            if (out_valid && out_ready && exp_q.size() > 0) begin
                b = exp_q.pop_front();
                chk("out_data", out_data, b.d);
                chk("out_last", out_last, b.l);
                got_q.push_back({out_last, out_data});
                popped++; desc_pops++;
                if (desc_pops == 1) reads_at_pop1 = desc_reads;
                if (b.l) begin done_due = cyc + 1; last_hs_cyc = cyc; end
            end
            prev_stall = out_valid && !out_ready;
            prev_beat  = {out_last, out_data};
            if (cyc == done_due) idle = 1'b1;
            if (cmd_valid && cmd_ready) begin
                idle = 1'b0; desc_reads = 0; desc_pops = 0; reads_at_pop1 = -1;
                acc_cyc = cyc; first_vld = -1; last_hs_cyc = -1; done_cyc = -1; err_cyc = -1;
                got_q.delete(); rd_cycles.delete();
`ifdef CNN_MEM_RD_BOUNDS_CHECK_EN
                oob = ({1'b0, cmd_addr} + {1'b0, cmd_len}) > 20'(MSIZE);
`else
                oob = 1'b0;
`endif
                if (oob || cmd_len == 0) begin
                    done_due = cyc + 1;
                    if (oob) err_due = cyc + 1;
                end else begin
                    for (int i = 0; i < int'(cmd_len); i++) begin
                        b.d = mem_arr[cnn_addr_t'(cmd_addr + cnn_addr_t'(i))];
                        b.l = (i == int'(cmd_len) - 1);
                        exp_q.push_back(b);
                    end
                    exp_addr = cmd_addr; reads_left = int'(cmd_len);
                end
            end
        end
        cyc++;
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = (cyc >= hold_until);
            endcase
        end
    end

    task automatic send(input int a, input int l);
        int n = 0;
        bit hs = 1'b0;
        cmd_addr = cnn_addr_t'(a); cmd_len = cnn_addr_t'(l); cmd_valid = 1'b1;
        while (!hs && n < 50) begin
            @(negedge clk); hs = cmd_ready;
            @(posedge clk); #1; n++;
        end
        cmd_valid = 1'b0;
        chk("cmd_accept_in_time", hs, 1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(posedge clk); #1;
        while (!(idle && exp_q.size() == 0) && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        chk({"finish_in_time_", name}, n < 3000, 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_mem_read"}, mem_bus.mem_read, 0);
        chk({tag, "_mem_cs"}, mem_bus.mem_chipselect, 0);
        chk({tag, "_mem_addr"}, mem_bus.mem_address, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
`ifdef CNN_MEM_RD_BOUNDS_CHECK_EN
        chk({tag, "_err"}, err, 0);
`endif
    endtask

    initial begin
        beat_t e;
        for (int i = 0; i < (1 << AW); i++) mem_arr[i] = cnn_byte_t'($urandom);
        for (int i = 0; i < 4; i++) mem_arr[100 + i] = cnn_byte_t'(8'hA0 + i);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk); chk_reset_vals("init");

        // basic read: hand-computed stream and timing
        @(posedge clk); #1; rmode = 0;
        send(100, 4); wait_idle("basic");
        chk("basic_nbytes", got_q.size(), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            e.l = (i == 3); e.d = cnn_byte_t'(8'hA0 + i);
            chk("basic_byte", got_q[i], e);
        end
        chk("basic_nreads", rd_cycles.size(), 4);
        if (rd_cycles.size() == 4) begin
            chk("basic_rd_start", rd_cycles[0] - acc_cyc, 1);
            chk("basic_rd_consec", rd_cycles[3] - rd_cycles[0], 3);
        end
        // accept edge + 1 + RD_LATENCY edges: visible in the third cycle after the accept cycle
        chk("basic_first_valid", first_vld - acc_cyc, 3);
        chk("basic_done_lat", done_cyc - last_hs_cyc, 1);

        // zero length
        send(500, 0); wait_idle("zero");
        chk("zero_nreads", rd_cycles.size(), 0);
        chk("zero_valid_seen", first_vld, -1);
        chk("zero_done_lat", done_cyc - acc_cyc, 1);
        @(negedge clk); chk("zero_ready_again", cmd_ready, 1);
        @(posedge clk); #1;

        // backpressure: exactly FIFO_DEPTH reads before the first pop
        rmode = 2; hold_until = cyc + 12;
        send(1000, 16); wait_idle("bp");
        chk("bp_reads_before_pop", reads_at_pop1, DEPTH);
        chk("bp_nbytes", got_q.size(), 16);

        // random ready
        rmode = 1;
        send(2000, 16); wait_idle("rnd_ready");
        chk("rnd_nbytes", got_q.size(), 16);

        // reset in the middle of a transfer
        rmode = 0;
        send(3000, 10);
        for (int n = 0; desc_pops < 2 && n < 100; n++) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk); chk_reset_vals("midrst");
        @(posedge clk); #1;
        send(3100, 2); wait_idle("post_rst");
        chk("post_rst_nbytes", got_q.size(), 2);
        if (got_q.size() == 2) chk("post_rst_byte0", got_q[0].d, mem_arr[3100]);

        // near the top of valid memory
        send(MSIZE - 1, 2); wait_idle("bound_hi");
`ifdef CNN_MEM_RD_BOUNDS_CHECK_EN
        chk("bound_hi_nreads", rd_cycles.size(), 0);
        chk("bound_hi_nbytes", got_q.size(), 0);
        chk("bound_hi_done_lat", done_cyc - acc_cyc, 1);
        chk("bound_hi_err_with_done", err_cyc, done_cyc);
`else
        chk("bound_hi_nbytes", got_q.size(), 2);
`endif
        send(MSIZE - 2, 2); wait_idle("bound_ok");
        chk("bound_ok_nbytes", got_q.size(), 2);

        // random descriptors, including address wrap and zero length
        for (int k = 0; k < 14; k++) begin
            int a, l;
            case (k % 4)
                0:       a = MSIZE - int'($urandom_range(0, 20));
                1:       a = (1 << AW) - int'($urandom_range(1, 6));
                default: a = int'($urandom_range(0, (1 << AW) - 1));
            endcase
            l = (k % 5 == 4) ? 0 : int'($urandom_range(1, 24));
            rmode = int'($urandom_range(0, 1));
            send(a, l); wait_idle("rand");
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
